// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared constants, host FSM states and operand beat layout
package dnn_pkg;

  localparam int DOT_LEN   = 4;
  localparam int ELEM_W    = 16;
  localparam int RES_W     = 32;
  localparam int DNN_BATCH = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_FULL,
    READ_REQ,
    DRAIN
  } host_state_t;

  // First member lands in the MSBs, so a0 occupies op_data[15:0].
  typedef struct packed {
    logic [ELEM_W-1:0] b3;
    logic [ELEM_W-1:0] a3;
    logic [ELEM_W-1:0] b2;
    logic [ELEM_W-1:0] a2;
    logic [ELEM_W-1:0] b1;
    logic [ELEM_W-1:0] a1;
    logic [ELEM_W-1:0] b0;
    logic [ELEM_W-1:0] a0;
  } op_beat_t;

endpackage

// File: rtl/dnn_result_fifo.sv
// rtl/dnn_result_fifo.sv - synchronous FIFO with registered write and read-through head
module dnn_result_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dnn_mac_host.sv
// rtl/dnn_mac_host.sv - issues MAC batches to the accelerator and re-streams its readout
module dnn_mac_host
  import dnn_pkg::*;
#(
  parameter int BATCH       = DNN_BATCH,
  parameter int TIMEOUT_CYC = 1024,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [127:0]      op_data,
  output logic              EN_mac,
  output logic [ELEM_W-1:0] mac_vecA_0,
  output logic [ELEM_W-1:0] mac_vecA_1,
  output logic [ELEM_W-1:0] mac_vecA_2,
  output logic [ELEM_W-1:0] mac_vecA_3,
  output logic [ELEM_W-1:0] mac_vecB_0,
  output logic [ELEM_W-1:0] mac_vecB_1,
  output logic [ELEM_W-1:0] mac_vecB_2,
  output logic [ELEM_W-1:0] mac_vecB_3,
  input  logic              RDY_mac,
  output logic              EN_readMem,
  input  logic              VALID_memVal,
  input  logic [RES_W-1:0]  memVal_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_last,
  output logic              batch_done,
  output logic              err_timeout,
  output logic              err_protocol
);

  localparam int CW  = $clog2(BATCH) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYC) + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  host_state_t      state, state_nxt;
  logic [CW-1:0]    issue_cnt, cap_cnt;
  logic [TW-1:0]    wait_cnt;
  logic             en_mac, en_read, timeout_hit;
  logic             push, cap_last;
  logic             fifo_full, fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [RES_W:0]   head;
  op_beat_t         beat;

  assign beat     = op_beat_t'(op_data);
  assign push     = VALID_memVal && (state == DRAIN);
  assign cap_last = (cap_cnt == CW'(BATCH - 1));

  always_comb begin
    state_nxt   = state;
    en_mac      = 1'b0;
    en_read     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:      state_nxt = ISSUE;
      ISSUE: begin
        en_mac = op_valid && RDY_mac;
        if (en_mac && issue_cnt == CW'(BATCH - 1)) state_nxt = WAIT_FULL;
      end
      WAIT_FULL: begin
        // RDY_mac dropping is the accelerator's only "buffer full" indication.
        if (!RDY_mac) state_nxt = READ_REQ;
        else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      READ_REQ: begin
        // The burst cannot be stalled, so hold off until a whole batch fits.
        if (fifo_count <= FCW'(FIFO_DEPTH - BATCH)) begin
          en_read   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN:     if (push && cap_last) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      issue_cnt    <= '0;
      cap_cnt      <= '0;
      wait_cnt     <= '0;
      batch_done   <= 1'b0;
      err_timeout  <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      state      <= state_nxt;
      batch_done <= push && cap_last;
      wait_cnt   <= (state == WAIT_FULL) ? wait_cnt + TW'(1) : '0;
      if (timeout_hit) err_timeout <= 1'b1;
      if (VALID_memVal && state != DRAIN) err_protocol <= 1'b1;
      if (state == IDLE) begin
        issue_cnt <= '0;
        cap_cnt   <= '0;
      end else begin
        if (en_mac) issue_cnt <= issue_cnt + CW'(1);
        if (push)   cap_cnt   <= cap_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && fifo_full));
  end

  dnn_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (res_ready),
    .din   ({cap_last, memVal_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign op_ready   = en_mac;
  assign EN_mac     = en_mac;
  assign EN_readMem = en_read;
  assign mac_vecA_0 = en_mac ? beat.a0 : '0;
  assign mac_vecA_1 = en_mac ? beat.a1 : '0;
  assign mac_vecA_2 = en_mac ? beat.a2 : '0;
  assign mac_vecA_3 = en_mac ? beat.a3 : '0;
  assign mac_vecB_0 = en_mac ? beat.b0 : '0;
  assign mac_vecB_1 = en_mac ? beat.b1 : '0;
  assign mac_vecB_2 = en_mac ? beat.b2 : '0;
  assign mac_vecB_3 = en_mac ? beat.b3 : '0;

  assign res_valid = !fifo_empty;
  assign res_data  = fifo_empty ? '0 : head[RES_W-1:0];
  assign res_last  = !fifo_empty && head[RES_W];

endmodule

// File: doc/dnn_mac_host.md
Name: dnn_mac_host

Overview:
- Initiator-side companion to the dnn_accelerator dot-product engine.
- Accepts a ready/valid stream of 4-element operand pairs and issues exactly BATCH MAC operations to the accelerator, honouring RDY_mac.
- Detects when the accelerator's result buffer is full, requests readout, and captures the burst of BATCH results.
- The readout burst cannot be stalled, so results are captured into an internal FIFO and re-emitted as a back-pressurable result stream with a last flag.

Parameters:
- BATCH, 64, MAC operations per batch; equals the accelerator result memory depth.
- TIMEOUT_CYC, 1024, max cycles in WAIT_FULL before flagging err_timeout.
- FIFO_DEPTH, 64, result FIFO depth; must be >= BATCH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat accepted this cycle
- op_data  in  128  {B3,A3,B2,A2,B1,A1,B0,A0}, 16 bits each, A0 in bits [15:0]
- EN_mac  out  1  MAC issue to accelerator
- mac_vecA_0..3, mac_vecB_0..3  out  16 each  operands to accelerator
- RDY_mac  in  1  accelerator ready
- EN_readMem  out  1  readout request pulse
- VALID_memVal  in  1  accelerator readout valid
- memVal_data  in  32  accelerator readout data
- res_valid  out  1  result stream valid
- res_ready  in  1  result stream ready
- res_data  out  32  dot-product result
- res_last  out  1  final result of a batch
- batch_done  out  1  one-cycle pulse when a batch is fully captured
- err_timeout  out  1  sticky flag; cleared only by rst
- err_protocol  out  1  sticky flag; cleared only by rst

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, counters 0; rst mid-operation aborts the batch and empties the FIFO.
- States: IDLE, ISSUE, WAIT_FULL, READ_REQ, DRAIN.
- IDLE: always goes to ISSUE next cycle.
- ISSUE:
  - Handshake: EN_mac = op_ready = op_valid && RDY_mac.
  - mac_vec* are combinationally driven from op_data; they are don't-care when EN_mac=0.
  - issue_cnt increments on each EN_mac.
  - When issue_cnt reaches BATCH, go to WAIT_FULL; the BATCH-th issue is the last one.
- WAIT_FULL:
  - op_ready=0.
  - Wait for RDY_mac==0, which indicates the accelerator buffer is full.
  - A wait counter starts at 0 on entry. If it reaches TIMEOUT_CYC with RDY_mac still high: set err_timeout, go to IDLE, FIFO contents kept.
- READ_REQ:
  - Waits until the FIFO holds at most FIFO_DEPTH-BATCH entries (empty when depths are equal).
  - Then drives EN_readMem=1 for exactly one cycle and goes to DRAIN.
- DRAIN:
  - Every cycle with VALID_memVal=1 pushes memVal_data into the FIFO and increments cap_cnt.
  - The tag bit last = (cap_cnt==BATCH-1) is stored with each entry.
  - After BATCH captures: batch_done pulses for 1 cycle, go to IDLE.
  - The accelerator delivers one value per cycle starting 2 cycles after EN_readMem; the block must not depend on the exact gap.
- VALID_memVal=1 in any state other than DRAIN: set err_protocol and discard the data.
- Output stream:
  - res_valid = FIFO not empty; res_data/res_last = FIFO head.
  - Pop when res_valid && res_ready.
  - Simultaneous push and pop on the same cycle is legal; count is unchanged.
  - Output draining overlaps with issuing the next batch.
- FIFO: pointers wrap modulo FIFO_DEPTH. Overflow is impossible by the READ_REQ rule; an assertion checks this.
- Latency: the first res_valid appears 1 cycle after the first capture (registered FIFO write, read-through head).
- Arithmetic: none on data; values pass through unmodified. Counters are clog2(BATCH)+1 bits.

Decomposition:
- Package dnn_pkg holds:
  - constants: DOT_LEN=4, ELEM_W=16, RES_W=32, DNN_BATCH=64
  - typedef host_state_t for the five states
  - packed struct op_beat_t for the op_data layout
- Sub-module dnn_result_fifo: synchronous FIFO, 33-bit entries (data + last), parameterised depth, push/pop/full/empty/count.

Test Plan:
- Reset, then a batch of 64 beats with A=(1,2,3,4) and B=(1,1,1,1) against an accelerator model:
  - required: exactly 64 EN_mac, then 1 EN_readMem pulse, then 64 res_data=10
  - res_last only on the 64th result; batch_done pulses once.
- op_valid toggled 1/0 every cycle while RDY_mac is held low for 3 cycles mid-batch:
  - required: EN_mac only when op_valid && RDY_mac, 64 issues total, no beat dropped or duplicated.
- res_ready=0 throughout the first batch, then the next batch is issued:
  - required: EN_readMem is withheld; once res_ready=1 drains the FIFO, EN_readMem fires.
- RDY_mac held at 1 after the 64th issue:
  - required: err_timeout=1 exactly TIMEOUT_CYC cycles after entering WAIT_FULL, state returns to IDLE, no EN_readMem.
- VALID_memVal pulsed in ISSUE with data 0xDEADBEEF:
  - required: err_protocol=1, FIFO count unchanged.
- rst asserted after 20 captures in DRAIN:
  - required: next cycle all outputs 0, res_valid=0, and a subsequent full batch completes normally.
